// File: rtl/mac_operand_source_if.sv
// Valid/ready stream bundle used for the MAC operand and result channels.
// The data width is set by the instantiating scope.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/mac_operand_source.sv
// Generates arithmetic-progression a/b operand streams and an optional accumulator seed
// for a MAC engine, then collects and counts the results coming back on d.
module mac_operand_source #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic                  simple_mul_i,
    input  logic [DATA_WIDTH-1:0] a_init_i,
    input  logic [DATA_WIDTH-1:0] a_step_i,
    input  logic [DATA_WIDTH-1:0] b_init_i,
    input  logic [DATA_WIDTH-1:0] b_step_i,
    input  logic [DATA_WIDTH-1:0] c_init_i,
    hwpe_stream_intf_stream.source a_o,
    hwpe_stream_intf_stream.source b_o,
    hwpe_stream_intf_stream.source c_o,
    hwpe_stream_intf_stream.sink   d_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  d_count_o,
    output logic [DATA_WIDTH-1:0] d_last_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  simple_mul_q, simple_mul_d;
    logic [DATA_WIDTH-1:0] a_step_q, a_step_d;
    logic [DATA_WIDTH-1:0] b_step_q, b_step_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
    logic [CNT_WIDTH-1:0]  pair_cnt_q, pair_cnt_d;
    logic                  ab_valid_q, ab_valid_d;
    logic                  c_valid_q, c_valid_d;
    logic [CNT_WIDTH-1:0]  d_count_q, d_count_d;
    logic [DATA_WIDTH-1:0] d_last_q, d_last_d;

    logic                  d_ready;
    logic                  ab_hs;
    logic                  c_hs;
    logic                  d_hs;
    logic                  last_pair;
    logic [CNT_WIDTH-1:0]  expected;

    assign d_ready   = (state_q == StRun) || (state_q == StDrain);
    assign ab_hs     = ab_valid_q && a_o.ready && b_o.ready;
    assign c_hs      = c_valid_q && c_o.ready;
    assign d_hs      = d_ready && d_i.valid;
    assign last_pair = (pair_cnt_q == len_q - CNT_WIDTH'(1));
    assign expected  = simple_mul_q ? len_q : CNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        simple_mul_d = simple_mul_q;
        a_step_d     = a_step_q;
        b_step_d     = b_step_q;
        a_data_d     = a_data_q;
        b_data_d     = b_data_q;
        c_data_d     = c_data_q;
        pair_cnt_d   = pair_cnt_q;
        ab_valid_d   = ab_valid_q;
        c_valid_d    = c_valid_q;
        d_count_d    = d_count_q;
        d_last_d     = d_last_q;

        // d_ready gates this to RUN/DRAIN, so the counters are frozen elsewhere.
        if (d_hs) begin
            d_count_d = d_count_q + CNT_WIDTH'(1);
            d_last_d  = d_i.data;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d        = len_i;
                    simple_mul_d = simple_mul_i;
                    a_step_d     = a_step_i;
                    b_step_d     = b_step_i;
                    a_data_d     = a_init_i;
                    b_data_d     = b_init_i;
                    c_data_d     = c_init_i;
                    pair_cnt_d   = '0;
                    d_count_d    = '0;
                    if (len_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StRun;
                        ab_valid_d = 1'b1;
                        c_valid_d  = !simple_mul_i;
                    end
                end
            end
            StRun: begin
                if (ab_hs) begin
                    a_data_d   = a_data_q + a_step_q;
                    b_data_d   = b_data_q + b_step_q;
                    pair_cnt_d = pair_cnt_q + CNT_WIDTH'(1);
                    if (last_pair) begin
                        ab_valid_d = 1'b0;
                    end
                end
                if (c_hs) begin
                    c_valid_d = 1'b0;
                end
                // Leave RUN on the same edge as the final operand handshake(s).
                if (!ab_valid_d && !c_valid_d) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (d_count_d >= expected) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            len_q        <= '0;
            simple_mul_q <= 1'b0;
            a_step_q     <= '0;
            b_step_q     <= '0;
            a_data_q     <= '0;
            b_data_q     <= '0;
            c_data_q     <= '0;
            pair_cnt_q   <= '0;
            ab_valid_q   <= 1'b0;
            c_valid_q    <= 1'b0;
            d_count_q    <= '0;
            d_last_q     <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            simple_mul_q <= simple_mul_d;
            a_step_q     <= a_step_d;
            b_step_q     <= b_step_d;
            a_data_q     <= a_data_d;
            b_data_q     <= b_data_d;
            c_data_q     <= c_data_d;
            pair_cnt_q   <= pair_cnt_d;
            ab_valid_q   <= ab_valid_d;
            c_valid_q    <= c_valid_d;
            d_count_q    <= d_count_d;
            d_last_q     <= d_last_d;
        end
    end

    assign a_o.valid = ab_valid_q;
    assign a_o.data  = a_data_q;
    assign a_o.strb  = '1;
    assign b_o.valid = ab_valid_q;
    assign b_o.data  = b_data_q;
    assign b_o.strb  = '1;
    assign c_o.valid = c_valid_q;
    assign c_o.data  = c_data_q;
    assign c_o.strb  = '1;
    assign d_i.ready = d_ready;

    assign busy_o    = d_ready;
    assign done_o    = (state_q == StDone);
    assign d_count_o = d_count_q;
    assign d_last_o  = d_last_q;

endmodule

// File: tb/tb_mac_operand_source.sv
// Directed bench for mac_operand_source: simple and accumulate jobs, split ready,
// wrap-around, zero-length job and mid-job reset.
module tb_mac_operand_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        simple_mul;
    logic [31:0] a_init, a_step, b_init, b_step, c_init;
    logic        busy, done;
    logic [15:0] d_count;
    logic [31:0] d_last;

    int n_cmp = 0;
    int n_err = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) b_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) c_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();

    mac_operand_source #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .simple_mul_i(simple_mul),
        .a_init_i    (a_init),
        .a_step_i    (a_step),
        .b_init_i    (b_init),
        .b_step_i    (b_step),
        .c_init_i    (c_init),
        .a_o         (a_if),
        .b_o         (b_if),
        .c_o         (c_if),
        .d_i         (d_if),
        .busy_o      (busy),
        .done_o      (done),
        .d_count_o   (d_count),
        .d_last_o    (d_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Simple-mul job with all readies high and one d beat per pair, fed during RUN.
    task automatic simple_job(input int n, input logic [31:0] a0, input logic [31:0] as,
                              input logic [31:0] b0, input logic [31:0] bs);
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        exp_a = a0;
        exp_b = b0;
        a_init = a0; a_step = as; b_init = b0; b_step = bs;
        len = 16'(n); simple_mul = 1'b1;
        a_if.ready = 1'b1; b_if.ready = 1'b1; c_if.ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sj_busy", busy, 1);
        check("sj_d_ready", d_if.ready, 1);
        check("sj_d_count_clr", d_count, 0);
        for (int k = 0; k < n; k++) begin
            d_if.valid = 1'b1;
            d_if.data  = 32'hA0 + 32'(k);
            check("sj_a_data", a_if.data, exp_a);
            check("sj_b_data", b_if.data, exp_b);
            check("sj_ab_valid", a_if.valid & b_if.valid, 1);
            check("sj_c_valid", c_if.valid, 0);
            tick();
            exp_a = exp_a + as;
            exp_b = exp_b + bs;
        end
        d_if.valid = 1'b0;
        check("sj_a_valid_off", a_if.valid, 0);
        check("sj_d_count", d_count, n);
        check("sj_d_last", d_last, 32'hA0 + 32'(n - 1));
        tick();
        check("sj_done", done, 1);
        tick();
        check("sj_done_off", done, 0);
        check("sj_idle_busy", busy, 0);
        check("sj_d_count_hold", d_count, n);
    endtask

    logic pa [7];
    logic pb [7];
    int   k3;

    initial begin
        rst_n = 1'b0;
        start = 1'b0; len = '0; simple_mul = 1'b0;
        a_init = '0; a_step = '0; b_init = '0; b_step = '0; c_init = '0;
        a_if.ready = 1'b0; b_if.ready = 1'b0; c_if.ready = 1'b0;
        d_if.valid = 1'b0; d_if.data = '0; d_if.strb = '1;
        tick();
        tick();
        check("rst_a_valid", a_if.valid, 0);
        check("rst_b_valid", b_if.valid, 0);
        check("rst_c_valid", c_if.valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d_ready", d_if.ready, 0);
        check("rst_d_count", d_count, 0);
        check("rst_d_last", d_last, 0);
        rst_n = 1'b1;
        tick();

        // a = 1,2,3,4 ; b = 2,2,2,2
        simple_job(4, 32'd1, 32'd1, 32'd2, 32'd0);
        check("strb_all_ones", a_if.strb, 4'hF);

        // Accumulate mode with c held off for three cycles.
        a_init = 32'd10; a_step = 32'd2; b_init = 32'd3; b_step = 32'd1; c_init = 32'd5;
        len = 16'd3; simple_mul = 1'b0;
        a_if.ready = 1'b1; b_if.ready = 1'b1; c_if.ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("acc_c_valid0", c_if.valid, 1);
        check("acc_c_data0", c_if.data, 32'd5);
        check("acc_a0", a_if.data, 32'd10);
        check("acc_b0", b_if.data, 32'd3);
        tick();
        check("acc_c_valid1", c_if.valid, 1);
        check("acc_c_data1", c_if.data, 32'd5);
        check("acc_a1", a_if.data, 32'd12);
        check("acc_b1", b_if.data, 32'd4);
        tick();
        check("acc_c_valid2", c_if.valid, 1);
        check("acc_a2", a_if.data, 32'd14);
        check("acc_b2", b_if.data, 32'd5);
        tick();
        check("acc_c_valid3", c_if.valid, 1);
        check("acc_c_data3", c_if.data, 32'd5);
        check("acc_ab_done", a_if.valid, 0);
        check("acc_busy_run", busy, 1);
        c_if.ready = 1'b1;
        tick();
        check("acc_c_off", c_if.valid, 0);
        check("acc_busy_drain", busy, 1);
        check("acc_not_done", done, 0);
        d_if.valid = 1'b1;
        d_if.data  = 32'h1234;
        tick();
        d_if.valid = 1'b0;
        check("acc_done", done, 1);
        check("acc_d_count", d_count, 1);
        check("acc_d_last", d_last, 32'h1234);
        tick();
        check("acc_done_off", done, 0);

        // Split ready: pairs move only on joint a/b ready.
        pa = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        pb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        a_init = 32'd100; a_step = 32'd5; b_init = 32'd7; b_step = 32'd3;
        len = 16'd3; simple_mul = 1'b1;
        a_if.ready = 1'b0; b_if.ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k3 = 0;
        for (int i = 0; i < 7; i++) begin
            a_if.ready = pa[i];
            b_if.ready = pb[i];
            check("split_valid", a_if.valid & b_if.valid, (k3 < 3) ? 1 : 0);
            check("split_a", a_if.data, 32'd100 + 32'd5 * 32'(k3));
            check("split_b", b_if.data, 32'd7 + 32'd3 * 32'(k3));
            tick();
            if (pa[i] && pb[i] && k3 < 3) k3++;
        end
        check("split_pairs", k3, 3);
        check("split_valid_off", a_if.valid, 0);
        check("split_busy", busy, 1);
        d_if.valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            d_if.data = 32'hB0 + 32'(j);
            tick();
        end
        d_if.valid = 1'b0;
        check("split_done", done, 1);
        check("split_d_count", d_count, 3);
        check("split_d_last", d_last, 32'hB2);
        tick();

        // a = FFFFFFFE, FFFFFFFF, 00000000 (wraps silently)
        simple_job(3, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0);

        // Zero-length job.
        len = 16'd0; simple_mul = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_a_valid", a_if.valid, 0);
        check("len0_c_valid", c_if.valid, 0);
        check("len0_busy", busy, 0);
        check("len0_d_count", d_count, 0);
        tick();
        check("len0_done_off", done, 0);

        // Reset after 2 of 8 pairs, then restart.
        a_init = 32'h50; a_step = 32'd1; b_init = 32'd0; b_step = 32'd1;
        len = 16'd8; simple_mul = 1'b1;
        a_if.ready = 1'b1; b_if.ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_a_data", a_if.data, 32'h52);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_if.valid | b_if.valid | c_if.valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_d_ready", d_if.ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_no_beat", a_if.valid, 0);
        check("post_rst_idle", busy, 0);
        simple_job(2, 32'h50, 32'd1, 32'd0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
